// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: opcodes, fetch FSM encodings and the
// PC/instruction payload carried through the skid buffer and IF/ID register.
package mips_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned OP_W     = 6;

   localparam logic [OP_W-1:0] OP_ANDI = 6'h0C;
   localparam logic [OP_W-1:0] OP_ORI  = 6'h0D;
   localparam logic [OP_W-1:0] OP_XORI = 6'h0E;
   localparam logic [OP_W-1:0] OP_LUI  = 6'h0F;

   localparam logic [XLEN-1:0] PC_INC  = 32'd4;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_FULL = 2'd1,
      S_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_word_t;

endpackage

// File: rtl/imm_ctrl_decode.sv
// Immediate-extension select: logical immediates and lui zero-extend,
// everything else (arithmetic, compares, loads/stores, branches) sign-extends.
module imm_ctrl_decode
   import mips_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       ext_sign
);

   always_comb begin
      ext_sign = 1'b1;
      case (opcode)
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: ext_sign = 1'b0;
         default:                          ext_sign = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch with a one-entry skid buffer and the IF/ID pipeline
// register; supports stall, flush and branch/jump redirect.
module fetch_decode_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic [5:0]  id_opcode,
   output logic [4:0]  id_rs,
   output logic [4:0]  id_rt,
   output logic [4:0]  id_rd,
   output logic [4:0]  id_shamt,
   output logic [5:0]  id_funct,
   output logic [15:0] id_immediate,
   output logic [25:0] id_target,
   output logic        id_ext_sign
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] addr_q, addr_d;
   fetch_word_t     skid_q, skid_d;
   fetch_word_t     id_q, id_d;
   logic            id_valid_q, id_valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         addr_q     <= RESET_PC;
         skid_q     <= '0;
         id_q       <= '0;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         skid_q     <= skid_d;
         id_q       <= id_d;
         id_valid_q <= id_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      skid_d     = skid_q;
      id_d       = id_q;
      id_valid_d = stall ? id_valid_q : 1'b0;

      case (state_q)
         S_REQ: begin
            if (imem_ack) begin
               pc_d = pc_q + PC_INC;
               if (stall) begin
                  skid_d  = '{pc: pc_q, instr: imem_rdata};
                  state_d = S_FULL;
               end else begin
                  id_d       = '{pc: pc_q, instr: imem_rdata};
                  id_valid_d = 1'b1;
               end
            end
         end
         S_FULL: begin
            if (!stall) begin
               id_d       = skid_q;
               id_valid_d = 1'b1;
               state_d    = S_REQ;
            end
         end
         S_DROP: begin
            if (imem_ack) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      if (flush) id_valid_d = 1'b0;

      // Redirect discards any word returning this cycle and the skid contents.
      if (redirect_valid) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         id_d       = id_q;
         id_valid_d = 1'b0;
         skid_d     = '0;
         state_d    = (imem_ack || (state_q == S_FULL)) ? S_REQ : S_DROP;
      end

      // A stale request keeps its address on the bus until it is acknowledged.
      addr_d = (state_d == S_DROP) ? addr_q : pc_d;
   end

   assign imem_req     = (state_q != S_FULL);
   assign imem_addr    = addr_q;

   assign id_valid     = id_valid_q;
   assign id_pc        = id_q.pc;
   assign id_instr     = id_q.instr;
   assign id_opcode    = id_q.instr[31:26];
   assign id_rs        = id_q.instr[25:21];
   assign id_rt        = id_q.instr[20:16];
   assign id_rd        = id_q.instr[15:11];
   assign id_shamt     = id_q.instr[10:6];
   assign id_funct     = id_q.instr[5:0];
   assign id_immediate = id_q.instr[15:0];
   assign id_target    = id_q.instr[25:0];

   imm_ctrl_decode u_imm_ctrl_decode (
      .opcode   (id_q.instr[31:26]),
      .ext_sign (id_ext_sign)
   );

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed table-driven bench for fetch_decode_stage: each row is the input
// for one cycle plus the outputs expected in that cycle before the edge.
module tb_fetch_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall, flush, redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_pc, id_instr;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [15:0] id_immediate;
   logic [25:0] id_target;
   logic        id_ext_sign;

   fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .stall(stall), .flush(flush),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
      .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_shamt(id_shamt), .id_funct(id_funct),
      .id_immediate(id_immediate), .id_target(id_target),
      .id_ext_sign(id_ext_sign)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ack;
      logic [31:0] rdata;
      logic        stall;
      logic        flush;
      logic        rv;
      logic [31:0] rpc;
      logic        e_req;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
      logic        e_sign;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   localparam logic [31:0] I0 = 32'h2008_0005;  // addi
   localparam logic [31:0] I1 = 32'h3409_FFFF;  // ori
   localparam logic [31:0] I2 = 32'h8C0A_0004;  // lw
   localparam logic [31:0] I3 = 32'h3C0B_1234;  // lui
   localparam logic [31:0] I4 = 32'h3128_00F0;  // andi
   localparam logic [31:0] I5 = 32'h3A6C_00FF;  // xori
   localparam logic [31:0] I6 = 32'h2810_8000;  // slti
   localparam logic [31:0] I7 = 32'h2C0E_FFFF;  // sltiu
   localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

   task automatic check(input string name, input int row, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
   endtask

   task automatic row(input logic ack, input logic [31:0] rdata, input logic st,
                      input logic fl, input logic rv, input logic [31:0] rpc,
                      input logic e_req, input logic [31:0] e_addr, input logic e_valid,
                      input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_sign);
      vec_t v;
      v.ack = ack; v.rdata = rdata; v.stall = st; v.flush = fl; v.rv = rv; v.rpc = rpc;
      v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
      v.e_pc = e_pc; v.e_instr = e_instr; v.e_sign = e_sign;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic ack, input logic [31:0] rdata, input logic st,
                        input logic fl, input logic rv, input logic [31:0] rpc);
      imem_ack = ack; imem_rdata = rdata; stall = st; flush = fl;
      redirect_valid = rv; redirect_pc = rpc;
   endtask

   initial begin
      //   ack rdata st fl rv rpc            | req addr          v  pc            instr sign
      row(1, I0,   0, 0, 0, 0,              1, 32'h0,         0, 32'h0,         32'h0, 1);
      row(1, I1,   0, 0, 0, 0,              1, 32'h4,         1, 32'h0,         I0,    1);
      row(0, 0,    0, 0, 0, 0,              1, 32'h8,         1, 32'h4,         I1,    0);
      row(0, 0,    0, 0, 0, 0,              1, 32'h8,         0, 32'h4,         I1,    0);
      row(1, I2,   0, 0, 0, 0,              1, 32'h8,         0, 32'h4,         I1,    0);
      row(0, 0,    0, 0, 0, 0,              1, 32'hC,         1, 32'h8,         I2,    1);
      row(0, 0,    0, 0, 0, 0,              1, 32'hC,         0, 32'h8,         I2,    1);
      row(1, I3,   0, 0, 0, 0,              1, 32'hC,         0, 32'h8,         I2,    1);
      row(1, I4,   1, 0, 0, 0,              1, 32'h10,        1, 32'hC,         I3,    0);
      row(0, 0,    1, 0, 0, 0,              0, 32'h14,        1, 32'hC,         I3,    0);
      row(0, 0,    0, 0, 0, 0,              0, 32'h14,        1, 32'hC,         I3,    0);
      row(1, I5,   0, 0, 0, 0,              1, 32'h14,        1, 32'h10,        I4,    0);
      row(0, 0,    0, 0, 1, 32'h103,        1, 32'h18,        1, 32'h14,        I5,    0);
      row(0, 0,    0, 0, 0, 0,              1, 32'h18,        0, 32'h14,        I5,    0);
      row(1, JUNK, 0, 0, 0, 0,              1, 32'h18,        0, 32'h14,        I5,    0);
      row(1, I6,   0, 0, 0, 0,              1, 32'h100,       0, 32'h14,        I5,    0);
      row(0, 0,    1, 1, 0, 0,              1, 32'h104,       1, 32'h100,       I6,    1);
      row(0, 0,    0, 0, 0, 0,              1, 32'h104,       0, 32'h100,       I6,    1);
      row(1, JUNK, 0, 0, 1, 32'hFFFF_FFFC,  1, 32'h104,       0, 32'h100,       I6,    1);
      row(1, I7,   0, 0, 0, 0,              1, 32'hFFFF_FFFC, 0, 32'h100,       I6,    1);
      row(0, 0,    0, 0, 0, 0,              1, 32'h0,         1, 32'hFFFF_FFFC, I7,    1);
      row(1, I0,   1, 0, 0, 0,              1, 32'h0,         0, 32'hFFFF_FFFC, I7,    1);
      row(0, 0,    1, 1, 1, 32'h200,        0, 32'h4,         0, 32'hFFFF_FFFC, I7,    1);
      row(0, 0,    0, 0, 0, 0,              1, 32'h200,       0, 32'hFFFF_FFFC, I7,    1);
      row(1, I1,   0, 0, 0, 0,              1, 32'h200,       0, 32'hFFFF_FFFC, I7,    1);

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].ack, vecs[i].rdata, vecs[i].stall, vecs[i].flush,
               vecs[i].rv, vecs[i].rpc);
         #1;
         check("imem_req",    i, 32'(imem_req),    32'(vecs[i].e_req));
         check("imem_addr",   i, imem_addr,        vecs[i].e_addr);
         check("id_valid",    i, 32'(id_valid),    32'(vecs[i].e_valid));
         check("id_pc",       i, id_pc,            vecs[i].e_pc);
         check("id_instr",    i, id_instr,         vecs[i].e_instr);
         check("id_ext_sign", i, 32'(id_ext_sign), 32'(vecs[i].e_sign));
         @(negedge clk);
      end

      // ID now holds ori 0x3409_FFFF fetched from 0x200.
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("fld_valid",  100, 32'(id_valid),     32'h1);
      check("fld_pc",     100, id_pc,             32'h200);
      check("fld_opcode", 100, 32'(id_opcode),    32'h0D);
      check("fld_rs",     100, 32'(id_rs),        32'h00);
      check("fld_rt",     100, 32'(id_rt),        32'h09);
      check("fld_rd",     100, 32'(id_rd),        32'h1F);
      check("fld_shamt",  100, 32'(id_shamt),     32'h1F);
      check("fld_funct",  100, 32'(id_funct),     32'h3F);
      check("fld_imm",    100, 32'(id_immediate), 32'hFFFF);
      check("fld_target", 100, 32'(id_target),    32'h009_FFFF);
      check("fld_addr",   100, imem_addr,         32'h204);

      // Asynchronous reset in the middle of an outstanding request.
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", 101, 32'(id_valid),    32'h0);
      check("rst_addr",  101, imem_addr,        32'h0);
      check("rst_req",   101, 32'(imem_req),    32'h1);
      check("rst_pc",    101, id_pc,            32'h0);
      check("rst_instr", 101, id_instr,         32'h0);
      check("rst_sign",  101, 32'(id_ext_sign), 32'h1);

      @(negedge clk);
      rst_n = 1'b1;
      drive(1, I3, 0, 0, 0, 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1;
      check("post_valid", 102, 32'(id_valid),    32'h1);
      check("post_pc",    102, id_pc,            32'h0);
      check("post_instr", 102, id_instr,         I3);
      check("post_sign",  102, 32'(id_ext_sign), 32'h0);
      check("post_addr",  102, imem_addr,        32'h4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction fetch unit plus IF/ID pipeline register for the 32-bit MIPS datapath.
- Generates sequential PC, handshakes with instruction memory, and holds the fetched word.
- Splits the word into fields, including the 16-bit immediate and the sign/zero select that drive the immediate-extension stage directly downstream.
- Supports stall, flush and branch/jump redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address (current PC).
- imem_ack  input  1  single-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  instruction word.
- stall  input  1  downstream cannot accept; the ID register holds.
- flush  input  1  invalidate the ID register.
- redirect_valid  input  1  load new PC (branch/jump).
- redirect_pc  input  32  target PC.
- id_valid  output  1  ID register holds a live instruction.
- id_pc  output  32  PC of the ID instruction.
- id_instr  output  32  raw instruction.
- id_opcode, id_rs, id_rt, id_rd, id_shamt, id_funct  output  6,5,5,5,5,6  fields of id_instr.
- id_immediate  output  16  id_instr[15:0].
- id_target  output  26  id_instr[25:0].
- id_ext_sign  output  1  1 = sign-extend immediate, 0 = zero-extend.

Behaviour:
- Reset, asynchronous:
  - pc = RESET_PC, state = S_REQ, skid buffer empty.
  - id_valid = 0, id_pc = 0, id_instr = 0, so all fields are 0 and id_ext_sign = 1.
- Field outputs are combinational slices of id_instr.
- id_ext_sign = 0 for opcodes 0x0C (andi), 0x0D (ori), 0x0E (xori) and 0x0F (lui); 1 for every other opcode (sltiu included).
- imem_req = 1 in S_REQ and S_DROP; imem_addr = pc.
- Memory protocol: once imem_req is high, imem_addr stays constant until imem_ack.
- States:
  - S_REQ: request outstanding for pc.
  - S_FULL: word captured in the skid buffer and waiting for stall to drop; imem_req = 0.
  - S_DROP: stale request outstanding; its data is discarded.
- S_REQ, imem_ack = 1, stall = 0: id_instr <= rdata, id_pc <= pc, id_valid <= 1, pc <= pc + 4, stay in S_REQ. With zero-wait memory, sustained throughput is 1 instruction per clock.
- S_REQ, imem_ack = 1, stall = 1: skid <= rdata, pc <= pc + 4 (skid_pc = old pc), go to S_FULL.
- S_FULL, stall = 0: ID <= skid, id_valid <= 1, go to S_REQ.
- No load into ID and stall = 0: id_valid <= 0 (bubble).
- stall = 1: id_valid, id_pc and id_instr hold.
- flush: id_valid <= 0 next edge; overrides stall. The skid buffer and pc are unaffected.
- redirect_valid, highest priority:
  - pc <= redirect_pc, id_valid <= 0, skid buffer cleared.
  - From S_REQ with no ack this cycle: go to S_DROP.
  - With an ack this cycle: data discarded, go to S_REQ.
  - From S_FULL or S_DROP: go to S_REQ or stay in S_DROP, respectively, per ack.
- S_DROP, on imem_ack: data discarded, go to S_REQ; the next request uses the new pc.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC + 4 wraps to 0. redirect_pc[1:0] is forced to 0.
- Simultaneous redirect and flush: same as redirect alone.
- Reset mid-request abandons the transaction. The memory must tolerate imem_req dropping without ack.

Decomposition:
- Package mips_pkg holds:
  - Opcode localparams (OP_ANDI, OP_ORI, OP_XORI, OP_LUI).
  - State encodings S_REQ, S_FULL, S_DROP.
  - PC increment constant 4.
- One combinational sub-module, imm_ctrl_decode: input opcode[5:0], output ext_sign. It is reused by the control unit.

Test Plan:
- Reset release, zero-wait memory returning 0x2008_0005, 0x3409_FFFF → imem_addr 0, then 4, then 8.
  - id_valid rises 1 cycle after the first ack.
  - id_immediate = 0x0005 with id_ext_sign = 1, then 0xFFFF with id_ext_sign = 0 (ori).
- 3-cycle memory latency → imem_addr stays at 0 until ack; id_valid pulses 1 for one cycle per ack, 0 between.
- stall = 1 during ack at pc 8 → ID holds the previous instruction and S_FULL is entered. Release stall → id_pc = 8, next imem_addr = 12, no instruction lost or duplicated.
- redirect_valid to 0x100 while the request at 0x10 is pending (ack 2 cycles later):
  - Address stays 0x10 until ack; that data never reaches ID.
  - Next request is at 0x100; id_valid = 0 throughout.
- pc = 0xFFFF_FFFC, ack → next imem_addr = 0; flush + stall together → id_valid = 0 next cycle.
- Assert rst_n = 0 mid-request → id_valid = 0 and imem_addr = RESET_PC immediately (asynchronous), id_ext_sign = 1.
